// File: rtl/chsel_mux_rr_pkg.sv
// Shared types and index helpers for the channel-select mux.
package chsel_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } chsel_mode_t;

    localparam int unsigned CNT_W = 16;

    function automatic int unsigned mod_add(int unsigned a, int unsigned b, int unsigned n);
        return (a + b) % n;
    endfunction

    function automatic int unsigned next_idx(int unsigned idx, int unsigned n);
        return mod_add(idx, 1, n);
    endfunction

endpackage

// File: rtl/chsel_mux_rr_if.sv
// Channel-side and output-side handshake bundle for chsel_mux_rr.
interface chsel_mux_rr_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_CH = 2,
    localparam int unsigned SEL_W = $clog2(NUM_CH)
);

    logic [NUM_CH*WIDTH-1:0]    in_data;
    logic [NUM_CH-1:0]          in_valid;
    logic [NUM_CH-1:0]          in_ready;
    chsel_mux_pkg::chsel_mode_t mode;
    logic [SEL_W-1:0]           sel;
    logic [WIDTH-1:0]           out_data;
    logic [SEL_W-1:0]           out_ch;
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid
    );

endinterface

// File: rtl/chsel_mux_rr_arb.sv
// Combinational round-robin arbiter: rotate requests by ptr, take the lowest, rotate back.
module chsel_rr_arb
    import chsel_mux_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  grant,
    output logic              grant_vld
);

    logic [NUM_CH-1:0] rot;
    logic [SEL_W-1:0]  off;
    logic              found;

    always_comb begin
        rot = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            rot[i] = req[SEL_W'(mod_add(32'(ptr), i, NUM_CH))];
        end

        off   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rot[i] && !found) begin
                off   = SEL_W'(i);
                found = 1'b1;
            end
        end

        grant     = SEL_W'(mod_add(32'(off), 32'(ptr), NUM_CH));
        grant_vld = |req;
    end

endmodule

// File: rtl/chsel_mux_rr.sv
// Registered NUM_CH-to-1 channel mux, fixed or round-robin select, valid/ready on both sides.
// Optional per-channel transfer counters behind `CHSEL_MUX_RR_CNT_EN.
module chsel_mux_rr
    import chsel_mux_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_CH = 2,
    localparam int unsigned SEL_W = $clog2(NUM_CH)
) (
    input  logic             clk,
    input  logic             rst,
    chsel_mux_rr_if.slave    bus
`ifdef CHSEL_MUX_RR_CNT_EN
    ,
    input  logic [SEL_W-1:0] cnt_rd_ch,
    output logic [CNT_W-1:0] cnt_rd_data
`endif
);

    logic [WIDTH-1:0] ch_data [NUM_CH];
    logic [SEL_W-1:0] rr_grant, gnt;
    logic             rr_vld, fix_vld, gnt_vld;
    logic             load, xfer;

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_data[i] = bus.in_data[i*WIDTH +: WIDTH];
        end
    end

    chsel_rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req       (bus.in_valid),
        .ptr       (rr_ptr_q),
        .grant     (rr_grant),
        .grant_vld (rr_vld)
    );

    // Loop compare keeps an out-of-range sel from ever indexing in_valid.
    always_comb begin
        fix_vld = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
                fix_vld = 1'b1;
            end
        end
    end

    always_comb begin
        gnt     = (bus.mode == MODE_RR) ? rr_grant : bus.sel;
        gnt_vld = (bus.mode == MODE_RR) ? rr_vld : fix_vld;
        load    = !out_valid_q || bus.out_ready;
        xfer    = load && gnt_vld;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            bus.in_ready[i] = xfer && (gnt == SEL_W'(i));
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
        if (xfer) begin
            out_data_d  = ch_data[gnt];
            out_ch_d    = gnt;
            out_valid_d = 1'b1;
            if (bus.mode == MODE_RR) begin
                rr_ptr_d = SEL_W'(next_idx(32'(gnt), NUM_CH));
            end
        end else if (load) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;

`ifdef CHSEL_MUX_RR_CNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_CH];
    logic [CNT_W-1:0] cnt_rd_q, cnt_rd_d;

    always_comb begin
        cnt_rd_d = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cnt_rd_ch == SEL_W'(i)) begin
                cnt_rd_d = cnt_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            cnt_rd_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (xfer && gnt == SEL_W'(i) && cnt_q[i] != '1) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
            cnt_rd_q <= cnt_rd_d;
        end
    end

    assign cnt_rd_data = cnt_rd_q;
`else
    // Counters compiled out; datapath above is unchanged.
`endif

endmodule
